// File: rtl/tmr_fault_monitor_pkg.sv
// Shared types for the TMR fault monitor: operating modes, the "no replica
// retired" marker and a small popcount helper for the 3-bit mismatch vector.
package tmr_fault_monitor_pkg;

  typedef enum logic [1:0] {
    MODE_TMR      = 2'd0,
    MODE_DEGRADED = 2'd1,
    MODE_FAILSAFE = 2'd2
  } mode_e;

  localparam logic [1:0] ID_NONE = 2'd3;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// Word-wide bitwise majority of three replicas, plus a flag per replica that
// is set when that replica differs from the majority in any bit.
module tmr_vote #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic [W-1:0] d2_i,
  output logic [W-1:0] vote_o,
  output logic [2:0]   mis_o
);

  // Majority per bit, then compare each replica against the result
  always_comb begin
    vote_o = (d0_i & d1_i) | (d0_i & d2_i) | (d1_i & d2_i);
    mis_o  = {(d2_i != vote_o), (d1_i != vote_o), (d0_i != vote_o)};
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Registered TMR voter with per-replica fault tracking. A replica that loses
// THRESH consecutive votes is retired and the block falls back to duplex
// compare; any disagreement it can no longer arbitrate drops it into a sticky
// fail-safe mode that only rst leaves.
// Optional readmission of the retired replica: TMR_FAULT_MONITOR_RECOVER_EN.
module tmr_fault_monitor
  import tmr_fault_monitor_pkg::*;
#(
  parameter int W      = 8,
  parameter int THRESH = 4
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
  ,
  parameter int RECOV  = 16
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic         corrected,
  output logic [1:0]   mode,
  output logic [1:0]   retired_id,
  output logic         fail
);

  localparam int CW = $clog2(THRESH + 1);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  mode_e               mode_q, mode_d;
  logic [1:0]          retiredId_q, retiredId_d;
  logic [2:0][CW-1:0]  cnt_q, cnt_d;
  logic                outValid_q, outValid_d;
  logic [W-1:0]        dout_q, dout_d;
  logic                corrected_q, corrected_d;

  logic [W-1:0]        vote;
  logic [2:0]          mis;
  logic [1:0]          hitCount;
  logic [1:0]          hitId;
  logic [W-1:0]        pairLo, pairHi;

`ifdef TMR_FAULT_MONITOR_RECOV_UNUSED_GUARD
`endif
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
  localparam int RW = $clog2(RECOV + 1);
  localparam logic [RW-1:0] RECOV_C = RW'(RECOV);
  logic [RW-1:0] recov_q, recov_d;
  logic [W-1:0]  spare;
`endif

  tmr_vote #(.W(W)) u_vote (
    .d0_i   (d0),
    .d1_i   (d1),
    .d2_i   (d2),
    .vote_o (vote),
    .mis_o  (mis)
  );

  // Next-state: vote or duplex-compare the sample and advance the mode FSM
  always_comb begin
    mode_d      = mode_q;
    retiredId_d = retiredId_q;
    cnt_d       = cnt_q;
    outValid_d  = 1'b0;
    dout_d      = dout_q;
    corrected_d = corrected_q;
    hitCount    = 2'd0;
    hitId       = ID_NONE;
    pairLo      = d0;
    pairHi      = d1;
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
    recov_d     = recov_q;
    spare       = d2;
`endif

    case (retiredId_q)
      2'd0: begin
        pairLo = d1;
        pairHi = d2;
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
        spare  = d0;
`endif
      end
      2'd1: begin
        pairLo = d0;
        pairHi = d2;
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
        spare  = d1;
`endif
      end
      default: begin
        pairLo = d0;
        pairHi = d1;
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
        spare  = d2;
`endif
      end
    endcase

    case (mode_q)
      MODE_TMR: begin
        if (in_valid) begin
          for (int i = 0; i < 3; i++) begin
            if (!mis[i]) begin
              cnt_d[i] = '0;
            end else if (cnt_q[i] != THRESH_C) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
            if (cnt_d[i] == THRESH_C) begin
              hitCount = hitCount + 2'd1;
              hitId    = 2'(i);
            end
          end
          if (hitCount >= 2'd2) begin
            mode_d      = MODE_FAILSAFE;
            cnt_d       = '0;
            dout_d      = '0;
            corrected_d = 1'b0;
          end else begin
            outValid_d  = 1'b1;
            dout_d      = vote;
            corrected_d = (popcount3(mis) == 2'd1);
            if (hitCount == 2'd1) begin
              mode_d      = MODE_DEGRADED;
              retiredId_d = hitId;
              cnt_d       = '0;
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
              recov_d     = '0;
`endif
            end
          end
        end
      end
      MODE_DEGRADED: begin
        if (in_valid) begin
          if (pairLo != pairHi) begin
            mode_d      = MODE_FAILSAFE;
            dout_d      = '0;
            corrected_d = 1'b0;
          end else begin
            outValid_d  = 1'b1;
            dout_d      = pairLo;
            corrected_d = 1'b0;
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
            if (spare != pairLo) begin
              recov_d = '0;
            end else if (recov_q != RECOV_C) begin
              recov_d = recov_q + 1'b1;
            end
            if (recov_d == RECOV_C) begin
              mode_d      = MODE_TMR;
              retiredId_d = ID_NONE;
              cnt_d       = '0;
              recov_d     = '0;
            end
`endif
          end
        end
      end
      default: begin
        outValid_d  = 1'b0;
        dout_d      = '0;
        corrected_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_TMR;
      retiredId_q <= ID_NONE;
      cnt_q       <= '0;
      outValid_q  <= 1'b0;
      dout_q      <= '0;
      corrected_q <= 1'b0;
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
      recov_q     <= '0;
`endif
    end else begin
      mode_q      <= mode_d;
      retiredId_q <= retiredId_d;
      cnt_q       <= cnt_d;
      outValid_q  <= outValid_d;
      dout_q      <= dout_d;
      corrected_q <= corrected_d;
`ifdef TMR_FAULT_MONITOR_RECOVER_EN
      recov_q     <= recov_d;
`endif
    end
  end

  assign out_valid  = outValid_q;
  assign dout       = dout_q;
  assign corrected  = corrected_q;
  assign mode       = mode_q;
  assign retired_id = retiredId_q;
  assign fail       = (mode_q == MODE_FAILSAFE);

endmodule
